// File: rtl/tx_frame_scheduler_pkg.sv
// Shared types and helpers for the TX frame scheduler: FSM encoding,
// header length field position and length-to-beat decode.
package tx_frame_scheduler_pkg;

   localparam int unsigned QW_W    = 10;
   localparam int unsigned MASK_W  = 8;
   localparam int unsigned LEN_MSB = 63;
   localparam int unsigned LEN_LSB = 32;
   localparam int unsigned LEN_W   = LEN_MSB - LEN_LSB + 1;

   typedef enum logic [5:0] {
      ST_IDLE      = 6'b000001,
      ST_HDR_WAIT  = 6'b000010,
      ST_HDR_EVAL  = 6'b000100,
      ST_WAIT_DATA = 6'b001000,
      ST_PUSH      = 6'b010000,
      ST_ERR       = 6'b100000
   } state_e;

   // Data qwords needed for a byte count, rounding a partial final beat up.
   function automatic logic [QW_W-1:0] len_qwords(input logic [LEN_W-1:0] b);
      return b[QW_W+2:3] + QW_W'(b[2:0] != 3'd0);
   endfunction

   function automatic logic [MASK_W-1:0] len_mask(input logic [2:0] rem);
      if (rem == 3'd0) return 8'hFF;
      return MASK_W'((9'd1 << rem) - 9'd1);
   endfunction

endpackage

// File: rtl/tx_frame_scheduler_desc_fifo.sv
// First-word-fall-through descriptor FIFO; full/empty come from
// pointers carrying one extra wrap bit.
module tx_desc_fifo #(
   parameter int unsigned W     = 27,
   parameter int unsigned DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         wr_en,
   input  logic [W-1:0] wr_data,
   output logic         full_c,
   input  logic         rd_en,
   output logic [W-1:0] rd_data_c,
   output logic         empty_c
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [PW:0]  wr_ptr;
   logic [PW:0]  rd_ptr;
   logic         do_wr;
   logic         do_rd;

   assign empty_c   = (wr_ptr == rd_ptr);
   assign full_c    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   assign do_wr     = wr_en && !full_c;
   assign do_rd     = rd_en && !empty_c;
   assign rd_data_c = mem[rd_ptr[PW-1:0]];

   // Storage is cleared on reset so the idle output payload reads as zero.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      end else begin
         if (do_wr) begin
            mem[wr_ptr[PW-1:0]] <= wr_data;
            wr_ptr              <= wr_ptr + (PW+1)'(1);
         end
         if (do_rd) rd_ptr <= rd_ptr + (PW+1)'(1);
      end
   end

endmodule

// File: rtl/tx_frame_scheduler.sv
// Parses TX ring frame headers behind the committed write pointer and
// queues {data address, qword count, last-beat mask} descriptors for the MAC.
module tx_frame_scheduler
   import tx_frame_scheduler_pkg::*;
#(
   parameter int unsigned AW         = 9,
   parameter int unsigned MAX_BYTES  = 8184,
   parameter int unsigned DESC_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              wr_addr_updated,
   input  logic [AW-1:0]     commited_wr_addr,
   output logic [AW-1:0]     hdr_rd_addr,
   input  logic [63:0]       hdr_rd_data,
   output logic              desc_valid,
   input  logic              desc_ready,
   output logic [AW-1:0]     desc_addr,
   output logic [QW_W-1:0]   desc_qwords,
   output logic [MASK_W-1:0] desc_last_valid,
   output logic [31:0]       frames_scheduled,
   output logic              err_bad_len
);

   localparam int unsigned DW = AW + QW_W + MASK_W;
   localparam int unsigned CW = ((AW > QW_W) ? AW : QW_W) + 1;

   state_e              state_q;
   state_e              state_d;
   logic                sync0;
   logic                sync1;
   logic [AW-1:0]       wr_q;
   logic [AW-1:0]       commit_sync;
   logic [AW-1:0]       hdr_ptr;
   logic [AW-1:0]       hdr_ptr_d;
   logic [AW-1:0]       avail;
   logic [QW_W-1:0]     qwords_q;
   logic [MASK_W-1:0]   mask_q;
   logic [LEN_W-1:0]    hdr_len;
   logic                bad_len_c;
   logic                push_c;
   logic                fifo_full_c;
   logic                fifo_empty_c;
   logic [DW-1:0]       fifo_rd_data_c;
   logic                unused_hdr;

   assign hdr_len    = hdr_rd_data[LEN_MSB:LEN_LSB];
   assign unused_hdr = ^hdr_rd_data[LEN_LSB-1:0];
   assign bad_len_c  = (hdr_len == '0) || (hdr_len > LEN_W'(MAX_BYTES));
   assign hdr_rd_addr = hdr_ptr;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      push_c    = 1'b0;
      hdr_ptr_d = hdr_ptr;
      case (state_q)
         ST_IDLE:      if (avail != '0) state_d = ST_HDR_WAIT;
         ST_HDR_WAIT:  state_d = ST_HDR_EVAL;
         ST_HDR_EVAL:  state_d = bad_len_c ? ST_ERR : ST_WAIT_DATA;
         ST_WAIT_DATA: if (CW'(avail) >= CW'(qwords_q) + CW'(1)) state_d = ST_PUSH;
         ST_PUSH: begin
            if (!fifo_full_c) begin
               push_c    = 1'b1;
               hdr_ptr_d = hdr_ptr + AW'(qwords_q) + AW'(1);
               state_d   = ST_IDLE;
            end
         end
         ST_ERR:       state_d = ST_ERR;
         default:      state_d = ST_IDLE;
      endcase
   end

   // avail is formed from the next header pointer so IDLE never sees a stale
   // count in the cycle after a push.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync0            <= 1'b0;
         sync1            <= 1'b0;
         wr_q             <= '0;
         commit_sync      <= '0;
         avail            <= '0;
         hdr_ptr          <= '0;
         qwords_q         <= '0;
         mask_q           <= '0;
         frames_scheduled <= '0;
         err_bad_len      <= 1'b0;
      end else begin
         sync0   <= wr_addr_updated;
         sync1   <= sync0;
         wr_q    <= commited_wr_addr;
         if (sync1) commit_sync <= wr_q;
         avail   <= commit_sync - hdr_ptr_d;
         hdr_ptr <= hdr_ptr_d;
         if (state_q == ST_HDR_EVAL) begin
            qwords_q <= len_qwords(hdr_len);
            mask_q   <= len_mask(hdr_len[2:0]);
         end
         if (push_c) frames_scheduled <= frames_scheduled + 32'd1;
         if (state_q == ST_ERR) err_bad_len <= 1'b1;
      end
   end

   tx_desc_fifo #(
      .W     (DW),
      .DEPTH (DESC_DEPTH)
   ) u_desc_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .wr_en     (push_c),
      .wr_data   ({hdr_ptr + AW'(1), qwords_q, mask_q}),
      .full_c    (fifo_full_c),
      .rd_en     (desc_ready),
      .rd_data_c (fifo_rd_data_c),
      .empty_c   (fifo_empty_c)
   );

   assign desc_valid = !fifo_empty_c;
   assign {desc_addr, desc_qwords, desc_last_valid} = fifo_rd_data_c;

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Scoreboard bench for tx_frame_scheduler: directed frames push expected
// descriptors; a negedge monitor pops and compares on every transfer.
module tb_tx_frame_scheduler;

   localparam int unsigned AW = 9;
   typedef logic [26:0] desc_t;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          wr_addr_updated;
   logic [AW-1:0] commited_wr_addr;
   logic [AW-1:0] hdr_rd_addr;
   logic [63:0]   hdr_rd_data;
   logic          desc_valid;
   logic          desc_ready;
   logic [AW-1:0] desc_addr;
   logic [9:0]    desc_qwords;
   logic [7:0]    desc_last_valid;
   logic [31:0]   frames_scheduled;
   logic          err_bad_len;

   logic [63:0] ring [512];
   desc_t       exp_q [$];
   int          tests = 0;
   int          fails = 0;

   tx_frame_scheduler #(.AW(AW), .MAX_BYTES(8184), .DESC_DEPTH(4)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .wr_addr_updated  (wr_addr_updated),
      .commited_wr_addr (commited_wr_addr),
      .hdr_rd_addr      (hdr_rd_addr),
      .hdr_rd_data      (hdr_rd_data),
      .desc_valid       (desc_valid),
      .desc_ready       (desc_ready),
      .desc_addr        (desc_addr),
      .desc_qwords      (desc_qwords),
      .desc_last_valid  (desc_last_valid),
      .frames_scheduled (frames_scheduled),
      .err_bad_len      (err_bad_len)
   );

   always #5 clk = ~clk;

   // Ring model with a 1-cycle registered read port.
   always @(posedge clk) hdr_rd_data <= ring[hdr_rd_addr];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      desc_t got;
      if (reset_n && desc_valid && desc_ready) begin
         got = {desc_addr, desc_qwords, desc_last_valid};
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_desc: got %0h expected none", got);
         end else begin
            check("desc", 64'(got), 64'(exp_q.pop_front()));
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic hdr(input int a, input int b);
      ring[a % 512] = {32'(b), 32'h0};
   endtask

   task automatic push_exp(input int a, input int q, input int m);
      exp_q.push_back({9'(a), 10'(q), 8'(m)});
   endtask

   task automatic commit(input int a);
      commited_wr_addr = AW'(a);
      wr_addr_updated  = 1'b1;
      tick(1);
      wr_addr_updated  = 1'b0;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
         tick(1);
         n++;
      end
      check(name, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic do_reset();
      reset_n          = 1'b0;
      wr_addr_updated  = 1'b0;
      commited_wr_addr = '0;
      tick(2);
      reset_n = 1'b1;
      tick(1);
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_hdr_rd_addr"}, 64'(hdr_rd_addr), 64'd0);
      check({tag, "_desc_valid"}, 64'(desc_valid), 64'd0);
      check({tag, "_desc_addr"}, 64'(desc_addr), 64'd0);
      check({tag, "_desc_qwords"}, 64'(desc_qwords), 64'd0);
      check({tag, "_desc_last_valid"}, 64'(desc_last_valid), 64'd0);
      check({tag, "_frames"}, 64'(frames_scheduled), 64'd0);
      check({tag, "_err"}, 64'(err_bad_len), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      for (int i = 0; i < 512; i++) ring[i] = '0;
      reset_n          = 1'b0;
      wr_addr_updated  = 1'b0;
      commited_wr_addr = '0;
      desc_ready       = 1'b1;
      tick(3);
      check_zero_outputs("reset");
      reset_n = 1'b1;
      tick(2);

      // Single frame, then partial last beats.
      hdr(0, 64);   push_exp(1, 8, 'hFF);  commit(9);  drain("single_drain");
      check("single_frames", 64'(frames_scheduled), 64'd1);
      hdr(9, 61);   push_exp(10, 8, 'h1F); commit(18); drain("b61_drain");
      hdr(18, 1);   push_exp(19, 1, 'h01); commit(20); drain("b1_drain");
      check("partial_frames", 64'(frames_scheduled), 64'd3);

      // Incremental commit: header first, then data in four steps of 25.
      hdr(20, 800); push_exp(21, 100, 'hFF);
      commit(21); tick(20); check("incr_hold0", 64'(desc_valid), 64'd0);
      commit(46); tick(20); check("incr_hold1", 64'(desc_valid), 64'd0);
      commit(71); tick(20); check("incr_hold2", 64'(desc_valid), 64'd0);
      commit(96); tick(20); check("incr_hold3", 64'(desc_valid), 64'd0);
      commit(121);
      k = 0;
      while (!desc_valid && k < 20) begin
         tick(1);
         k++;
      end
      check("incr_latency", 64'(k), 64'd5);
      drain("incr_drain");

      // Pad to 505, then a frame straddling the end of the ring.
      hdr(121, 3064); push_exp(122, 383, 'hFF); commit(505); drain("pad_drain");
      hdr(505, 80);   push_exp(506, 10, 'hFF);  commit(4);   drain("wrap_drain");
      tick(2);
      check("wrap_hdr_ptr", 64'(hdr_rd_addr), 64'd4);
      hdr(4, 16);     push_exp(5, 2, 'hFF);     commit(7);   drain("post_wrap_drain");
      tick(2);
      check("post_wrap_hdr_ptr", 64'(hdr_rd_addr), 64'd7);
      check("post_wrap_frames", 64'(frames_scheduled), 64'd7);

      // Backpressure: six minimal frames against a stalled consumer.
      desc_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         hdr(7 + 2 * i, 1);
         push_exp(8 + 2 * i, 1, 'h01);
      end
      commit(19);
      tick(80);
      check("bp_valid", 64'(desc_valid), 64'd1);
      check("bp_head_addr", 64'(desc_addr), 64'd8);
      check("bp_hdr_ptr", 64'(hdr_rd_addr), 64'd15);
      check("bp_frames", 64'(frames_scheduled), 64'd11);
      desc_ready = 1'b1;
      drain("bp_drain");
      tick(2);
      check("bp_final_frames", 64'(frames_scheduled), 64'd13);
      check("bp_final_hdr_ptr", 64'(hdr_rd_addr), 64'd19);

      // Zero-length header is fatal and issues nothing.
      hdr(19, 0); commit(20); tick(20);
      check("bad_len_err", 64'(err_bad_len), 64'd1);
      check("bad_len_valid", 64'(desc_valid), 64'd0);
      check("bad_len_frames", 64'(frames_scheduled), 64'd13);

      // Reset clears everything; parsing restarts at address 0.
      reset_n = 1'b0;
      commited_wr_addr = '0;
      tick(2);
      check_zero_outputs("midreset");
      reset_n = 1'b1;
      tick(1);
      hdr(0, 24); push_exp(1, 3, 'hFF); commit(4); drain("restart_drain");
      check("restart_frames", 64'(frames_scheduled), 64'd1);
      check("restart_err", 64'(err_bad_len), 64'd0);

      // Length boundaries: MAX_BYTES is legal, anything above is not.
      hdr(4, 8184); commit(5); tick(20);
      check("max_len_err", 64'(err_bad_len), 64'd0);
      do_reset();
      hdr(0, 8192); commit(1); tick(20);
      check("over_len_err", 64'(err_bad_len), 64'd1);
      check("over_len_valid", 64'(desc_valid), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
